// File: rtl/vr_fifo_pkg.sv
// Shared types and helpers for the valid-ready FIFO family.
// Holds the fill-mode enum and the wrapping pointer increment.
package vr_fifo_pkg;

  typedef enum logic {
    FIFO_BLOCKING  = 1'b0,
    FIFO_OVERWRITE = 1'b1
  } fifo_mode_e;

  // Wraps at depth-1 explicitly so non-power-of-two depths index correctly.
  function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/vr_fifo_ext_ptr.sv
// Circular pointer register for vr_fifo_ext: increments on inc, wraps at
// DEPTH-1, synchronous clear for flush, asynchronous active-low reset.
module vr_fifo_ptr
  import vr_fifo_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             clr,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  logic [PTR_W-1:0] ptr_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ptr_q <= '0;
    end else if (clr) begin
      ptr_q <= '0;
    end else if (inc) begin
      ptr_q <= PTR_W'(next_ptr(32'(ptr_q), DEPTH));
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/vr_fifo_ext.sv
// Valid-ready FIFO with any-integer depth, occupancy count, almost flags,
// synchronous flush and optional overwrite-oldest mode.
module vr_fifo_ext
  import vr_fifo_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int DATA_W    = 32,
  parameter int AF_THRESH = DEPTH - 1,
  parameter int AE_THRESH = 1,
  parameter int MODE      = 0,
  parameter int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              en,
  input  logic              flush,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  count,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              drop
);

  localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic OVERWRITE = (MODE == int'(FIFO_OVERWRITE));

  if (DEPTH < 2) begin : g_chk_depth
    $error("vr_fifo_ext: DEPTH must be at least 2");
  end
  if (AF_THRESH > DEPTH) begin : g_chk_af
    $error("vr_fifo_ext: AF_THRESH must not exceed DEPTH");
  end
  if (AE_THRESH >= DEPTH) begin : g_chk_ae
    $error("vr_fifo_ext: AE_THRESH must be below DEPTH");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_nxt;
  logic              drop_q;

  logic full;
  logic empty;
  logic in_shake;
  logic out_shake;
  logic overwrite;
  logic clr;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // Handshake qualifiers depend only on en, flush and registered count.
  assign out_valid = en & ~flush & ~empty;
  assign in_ready  = en & ~flush & (~full | OVERWRITE);

  assign in_shake  = in_valid & in_ready;
  assign out_shake = out_valid & out_ready;
  assign overwrite = OVERWRITE & full & in_shake & ~out_shake;
  assign clr       = en & flush;

  vr_fifo_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wr_ptr (
    .clk  (clk),
    .nrst (nrst),
    .clr  (clr),
    .inc  (in_shake),
    .ptr  (wr_ptr)
  );

  // Overwriting a full FIFO discards the head, so the read side advances too.
  vr_fifo_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd_ptr (
    .clk  (clk),
    .nrst (nrst),
    .clr  (clr),
    .inc  (out_shake | overwrite),
    .ptr  (rd_ptr)
  );

  always_comb begin
    count_nxt = count_q;
    if (clr) begin
      count_nxt = '0;
    end else if (in_shake && !out_shake && !full) begin
      count_nxt = count_q + 1'b1;
    end else if (out_shake && !in_shake) begin
      count_nxt = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count_q <= '0;
      drop_q  <= 1'b0;
    end else if (en) begin
      count_q <= count_nxt;
      drop_q  <= overwrite;
    end
  end

  always_ff @(posedge clk) begin
    if (in_shake) begin
      mem[wr_ptr] <= in_data;
    end
  end

  assign out_data     = mem[rd_ptr];
  assign count        = count_q;
  assign almost_full  = (count_q >= CNT_W'(AF_THRESH));
  assign almost_empty = (count_q <= CNT_W'(AE_THRESH));
  assign drop         = drop_q & en;

endmodule

// File: tb/tb_vr_fifo_ext.sv
// Directed testbench for vr_fifo_ext: a DEPTH=5 blocking instance (a_*)
// and a DEPTH=4 overwrite instance (b_*).
module tb_vr_fifo_ext;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  logic        a_en, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [31:0] a_in_data, a_out_data;
  logic [2:0]  a_count;
  logic        a_af, a_ae, a_drop;

  logic        b_en, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [31:0] b_in_data, b_out_data;
  logic [2:0]  b_count;
  logic        b_af, b_ae, b_drop;

  int tests = 0;
  int fails = 0;

  vr_fifo_ext #(.DEPTH(5), .DATA_W(32), .MODE(0)) u_a (
    .clk(clk), .nrst(nrst), .en(a_en), .flush(a_flush),
    .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .count(a_count), .almost_full(a_af), .almost_empty(a_ae), .drop(a_drop)
  );

  vr_fifo_ext #(.DEPTH(4), .DATA_W(32), .MODE(1)) u_b (
    .clk(clk), .nrst(nrst), .en(b_en), .flush(b_flush),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .count(b_count), .almost_full(b_af), .almost_empty(b_ae), .drop(b_drop)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [31:0] d);
    a_in_data = d; a_in_valid = 1'b1; a_out_ready = 1'b0;
    tick();
    a_in_valid = 1'b0;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    #1;
    tests++; if (a_count !== 3'd0) begin fails++; $display("FAIL reset_count got %0d want 0", a_count); end
    tests++; if (a_out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", a_out_valid); end
    tests++; if (a_af !== 1'b0 || a_ae !== 1'b1) begin fails++; $display("FAIL reset_flags got af=%b ae=%b want af=0 ae=1", a_af, a_ae); end
    tests++; if (a_drop !== 1'b0 || b_drop !== 1'b0) begin fails++; $display("FAIL reset_drop got a=%b b=%b want 0", a_drop, b_drop); end
    tests++; if (a_in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", a_in_ready); end
    @(negedge clk);
    nrst = 1'b1;
    tick();
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 5; i++) begin
      tests++; if (a_in_ready !== 1'b1) begin fails++; $display("FAIL fill_in_ready[%0d] got %b want 1", i, a_in_ready); end
      push_a(32'h10 + i);
      tests++; if (a_count !== 3'(i + 1)) begin fails++; $display("FAIL fill_count[%0d] got %0d want %0d", i, a_count, i + 1); end
      tests++; if (a_af !== (i + 1 >= 4) || a_ae !== (i + 1 <= 1)) begin
        fails++; $display("FAIL fill_flags[%0d] got af=%b ae=%b want af=%b ae=%b", i, a_af, a_ae, i + 1 >= 4, i + 1 <= 1);
      end
    end
    tests++; if (a_in_ready !== 1'b0) begin fails++; $display("FAIL full_in_ready got %b want 0", a_in_ready); end
    push_a(32'h15);
    tests++; if (a_count !== 3'd5) begin fails++; $display("FAIL sixth_write_count got %0d want 5", a_count); end
    a_out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tests++; if (a_out_valid !== 1'b1 || a_out_data !== 32'h10 + i) begin
        fails++; $display("FAIL drain[%0d] got v=%b d=%h want v=1 d=%h", i, a_out_valid, a_out_data, 32'h10 + i);
      end
      tick();
    end
    a_out_ready = 1'b0;
    tests++; if (a_count !== 3'd0 || a_out_valid !== 1'b0 || a_ae !== 1'b1) begin
      fails++; $display("FAIL drained got cnt=%0d v=%b ae=%b want 0 0 1", a_count, a_out_valid, a_ae);
    end
  endtask

  task automatic test_wrap();
    a_in_valid = 1'b1; a_out_ready = 1'b1;
    for (int i = 0; i < 23; i++) begin
      a_in_data = 32'h100 + i;
      if (i > 0) begin
        tests++; if (a_out_valid !== 1'b1 || a_out_data !== 32'h100 + i - 1) begin
          fails++; $display("FAIL wrap[%0d] got v=%b d=%h want v=1 d=%h", i, a_out_valid, a_out_data, 32'h100 + i - 1);
        end
      end
      tick();
      tests++; if (a_count > 3'd1) begin fails++; $display("FAIL wrap_count[%0d] got %0d want <=1", i, a_count); end
    end
    a_in_valid = 1'b0;
    tests++; if (a_out_data !== 32'h116) begin fails++; $display("FAIL wrap_last got %h want 116", a_out_data); end
    tick();
    a_out_ready = 1'b0;
    tests++; if (a_count !== 3'd0) begin fails++; $display("FAIL wrap_end_count got %0d want 0", a_count); end
  endtask

  task automatic test_full_simul();
    for (int i = 0; i < 5; i++) push_a(32'h20 + i);
    a_in_valid = 1'b1; a_in_data = 32'h77; a_out_ready = 1'b1;
    tick();
    a_in_valid = 1'b0; a_out_ready = 1'b0;
    tests++; if (a_count !== 3'd4) begin fails++; $display("FAIL full_simul_count got %0d want 4", a_count); end
    tests++; if (a_in_ready !== 1'b1) begin fails++; $display("FAIL full_simul_in_ready got %b want 1", a_in_ready); end
    a_out_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      tests++; if (a_out_data !== 32'h20 + i) begin fails++; $display("FAIL full_simul_rd[%0d] got %h want %h", i, a_out_data, 32'h20 + i); end
      tick();
    end
    a_out_ready = 1'b0;
    tests++; if (a_out_valid !== 1'b0) begin fails++; $display("FAIL full_simul_empty got v=%b want 0", a_out_valid); end
  endtask

  task automatic test_overwrite();
    b_out_ready = 1'b0; b_in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b_in_data = 32'hA0 + i;
      tick();
    end
    tests++; if (b_count !== 3'd4 || b_drop !== 1'b0) begin fails++; $display("FAIL ovw_full got cnt=%0d drop=%b want 4 0", b_count, b_drop); end
    tests++; if (b_in_ready !== 1'b1) begin fails++; $display("FAIL ovw_in_ready got %b want 1", b_in_ready); end
    b_in_data = 32'hA4;
    tick();
    b_in_valid = 1'b0;
    tests++; if (b_drop !== 1'b1 || b_count !== 3'd4) begin fails++; $display("FAIL ovw_drop got drop=%b cnt=%0d want 1 4", b_drop, b_count); end
    tick();
    tests++; if (b_drop !== 1'b0) begin fails++; $display("FAIL ovw_drop_pulse got %b want 0", b_drop); end
    b_out_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      tests++; if (b_out_valid !== 1'b1 || b_out_data !== 32'hA0 + i) begin
        fails++; $display("FAIL ovw_rd[%0d] got v=%b d=%h want v=1 d=%h", i, b_out_valid, b_out_data, 32'hA0 + i);
      end
      tick();
    end
    b_out_ready = 1'b0;
    tests++; if (b_count !== 3'd0) begin fails++; $display("FAIL ovw_end_count got %0d want 0", b_count); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) push_a(32'h30 + i);
    a_flush = 1'b1; a_in_valid = 1'b1; a_in_data = 32'h99; a_out_ready = 1'b1;
    #1;
    tests++; if (a_in_ready !== 1'b0 || a_out_valid !== 1'b0) begin
      fails++; $display("FAIL flush_block got rdy=%b v=%b want 0 0", a_in_ready, a_out_valid);
    end
    tick();
    a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0;
    tests++; if (a_count !== 3'd0 || a_out_valid !== 1'b0) begin
      fails++; $display("FAIL flush_clear got cnt=%0d v=%b want 0 0", a_count, a_out_valid);
    end
    push_a(32'h55);
    tests++; if (a_out_valid !== 1'b1 || a_out_data !== 32'h55) begin
      fails++; $display("FAIL flush_rewrite got v=%b d=%h want v=1 d=55", a_out_valid, a_out_data);
    end
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
    tests++; if (a_count !== 3'd0) begin fails++; $display("FAIL flush_end_count got %0d want 0", a_count); end
  endtask

  task automatic test_enable();
    push_a(32'h40);
    push_a(32'h41);
    a_en = 1'b0; a_in_valid = 1'b1; a_in_data = 32'h42; a_out_ready = 1'b1;
    #1;
    tests++; if (a_in_ready !== 1'b0 || a_out_valid !== 1'b0) begin
      fails++; $display("FAIL en_low_hs got rdy=%b v=%b want 0 0", a_in_ready, a_out_valid);
    end
    tick();
    tick();
    tests++; if (a_count !== 3'd2) begin fails++; $display("FAIL en_low_hold got %0d want 2", a_count); end
    a_en = 1'b1; a_in_valid = 1'b0;
    #1;
    tests++; if (a_out_data !== 32'h40) begin fails++; $display("FAIL en_rd0 got %h want 40", a_out_data); end
    tick();
    tests++; if (a_out_data !== 32'h41) begin fails++; $display("FAIL en_rd1 got %h want 41", a_out_data); end
    tick();
    a_out_ready = 1'b0;
    tests++; if (a_count !== 3'd0) begin fails++; $display("FAIL en_end_count got %0d want 0", a_count); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) push_a(32'h60 + i);
    tests++; if (a_count !== 3'd3) begin fails++; $display("FAIL arst_pre got %0d want 3", a_count); end
    #2;
    nrst = 1'b0;
    #1;
    tests++; if (a_count !== 3'd0 || a_out_valid !== 1'b0) begin
      fails++; $display("FAIL arst_clear got cnt=%0d v=%b want 0 0", a_count, a_out_valid);
    end
    @(negedge clk);
    nrst = 1'b1;
    tick();
  endtask

  initial begin
    a_en = 1'b1; a_flush = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
    b_en = 1'b1; b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
    test_reset();
    test_fill_drain();
    test_wrap();
    test_full_simul();
    test_overwrite();
    test_flush();
    test_enable();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
